// File: rtl/block_motion_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : block_motion_sequencer
// Description : Moves the 10x10 player block on the 640x480 VGA field.
//               The system clock is divided into a move tick. On each tick
//               the four button requests are sampled. One of them is granted
//               round-robin, and a single bounded step is applied: the block
//               wraps horizontally and is clamped vertically above the sand.
// Ports       : clk          - system clock
//               rst          - asynchronous active-high reset
//               enable_i     - tick divider runs while high
//               right_i      - move-right request (index 0)
//               left_i       - move-left request (index 1)
//               down_i       - move-down request (index 2)
//               up_i         - move-up request (index 3)
//               xpos_o       - block centre hCount
//               ypos_o       - block centre vCount
//               grant_o      - one-hot granted request
//               busy_o       - high while a move sequence is in progress
//               step_done_o  - one-cycle pulse after a position update
//               landed_o     - block is resting on the sand
// Revision    : 1.0 - initial release
// ============================================================================
module block_motion_sequencer #(
    parameter int TICK_DIV = 4,
    parameter int STEP     = 2,
    parameter int HALF     = 5,
    parameter int X_MIN    = 144,
    parameter int X_MAX    = 783,
    parameter int Y_MIN    = 35,
    parameter int SAND_TOP = 400,
    parameter int X_RST    = 450,
    parameter int Y_RST    = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_i,
    input  logic       right_i,
    input  logic       left_i,
    input  logic       down_i,
    input  logic       up_i,
    output logic [9:0] xpos_o,
    output logic [9:0] ypos_o,
    output logic [3:0] grant_o,
    output logic       busy_o,
    output logic       step_done_o,
    output logic       landed_o
);

    localparam int              CNT_W      = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TICK_DIV - 1);
    localparam logic [9:0]      c_step     = 10'(STEP);
    localparam logic [9:0]      c_x_lo     = 10'(X_MIN + HALF);
    localparam logic [9:0]      c_x_hi     = 10'(X_MAX - HALF);
    localparam logic [9:0]      c_y_lo     = 10'(Y_MIN + HALF);
    // Resting row: bottom edge of the block sits just above the sand.
    localparam logic [9:0]      c_y_hi     = 10'(SAND_TOP - HALF - 1);
    localparam logic [9:0]      c_x_rst    = 10'(X_RST);
    localparam logic [9:0]      c_y_rst    = 10'(Y_RST);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARB   = 2'd1,
        S_APPLY = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       req_q;
    logic [3:0]       grant_q;
    logic [1:0]       ptr_q;
    logic [9:0]       xpos_q;
    logic [9:0]       ypos_q;
    logic             busy_q;
    logic             step_done_q;
    logic             landed_q;

    logic             tick;
    logic [3:0]       grant_d;
    logic [1:0]       ptr_d;
    logic [9:0]       xpos_d;
    logic [9:0]       ypos_d;

    assign tick = enable_i && (cnt_q == c_cnt_last);

    // Round-robin search starting at the pointer position.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        grant_d = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && req_q[idx]) begin
                grant_d[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    // Pointer moves to the index just after the winner.
    always_comb begin
        ptr_d = ptr_q;
        case (grant_q)
            4'b0001: ptr_d = 2'd1;
            4'b0010: ptr_d = 2'd2;
            4'b0100: ptr_d = 2'd3;
            4'b1000: ptr_d = 2'd0;
            default: ptr_d = ptr_q;
        endcase
    end

    // Bounds are tested before any subtraction so nothing can underflow.
    always_comb begin
        xpos_d = xpos_q;
        ypos_d = ypos_q;
        if (grant_q[0]) begin
            xpos_d = (xpos_q + c_step > c_x_hi) ? c_x_lo : xpos_q + c_step;
        end else if (grant_q[1]) begin
            xpos_d = (xpos_q < c_x_lo + c_step) ? c_x_hi : xpos_q - c_step;
        end else if (grant_q[2]) begin
            ypos_d = (ypos_q + c_step >= c_y_hi) ? c_y_hi : ypos_q + c_step;
        end else if (grant_q[3]) begin
            ypos_d = (ypos_q < c_y_lo + c_step) ? c_y_lo : ypos_q - c_step;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            grant_q     <= '0;
            ptr_q       <= '0;
            xpos_q      <= c_x_rst;
            ypos_q      <= c_y_rst;
            busy_q      <= 1'b0;
            step_done_q <= 1'b0;
            landed_q    <= 1'b0;
        end else begin
            step_done_q <= 1'b0;
            if (enable_i) begin
                cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (tick) begin
                        req_q   <= {up_i, down_i, left_i, right_i};
                        busy_q  <= 1'b1;
                        state_q <= S_ARB;
                    end
                end
                S_ARB: begin
                    grant_q <= grant_d;
                    state_q <= S_APPLY;
                end
                S_APPLY: begin
                    xpos_q   <= xpos_d;
                    ypos_q   <= ypos_d;
                    landed_q <= (ypos_d == c_y_hi);
                    if (|grant_q) begin
                        ptr_q       <= ptr_d;
                        step_done_q <= 1'b1;
                    end
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign xpos_o      = xpos_q;
    assign ypos_o      = ypos_q;
    assign grant_o     = grant_q;
    assign busy_o      = busy_q;
    assign step_done_o = step_done_q;
    assign landed_o    = landed_q;

endmodule
`default_nettype wire

// File: tb/tb_block_motion_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_motion_sequencer
// Description : Directed self-checking bench for block_motion_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_block_motion_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       right, left, down, up;
    logic [9:0] xpos, ypos;
    logic [3:0] grant;
    logic       busy, step_done, landed;

    int n_chk  = 0;
    int n_pass = 0;

    block_motion_sequencer u_dut (
        .clk         (clk),
        .rst         (rst),
        .enable_i    (enable),
        .right_i     (right),
        .left_i      (left),
        .down_i      (down),
        .up_i        (up),
        .xpos_o      (xpos),
        .ypos_o      (ypos),
        .grant_o     (grant),
        .busy_o      (busy),
        .step_done_o (step_done),
        .landed_o    (landed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    endtask

    // Present a request pattern, wait for the sequence that samples it and
    // optionally check grant (T+2) and the updated outputs (T+3).
    task automatic do_step(input logic [3:0] req, input logic chk,
                           input logic [3:0] eg, input logic [9:0] ex,
                           input logic [9:0] ey, input logic el);
        int n;
        {up, down, left, right} = req;
        n = 0;
        while (busy && n < 20) begin @(negedge clk); n++; end
        n = 0;
        while (!busy && n < 20) begin @(negedge clk); n++; end
        if (!busy) begin
            check("busy_wait", busy, 1);
        end else begin
            @(negedge clk);
            if (chk) check("grant", grant, eg);
            @(negedge clk);
            if (chk) begin
                check("xpos", xpos, ex);
                check("ypos", ypos, ey);
                check("landed", landed, el);
                check("step_done", step_done, 1);
                check("grant_clr", grant, 0);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic any_busy, any_grant, any_move;
        logic [9:0] ey;

        rst = 1'b1; enable = 1'b1;
        {up, down, left, right} = 4'b0000;
        repeat (3) @(negedge clk);
        check("rst_xpos", xpos, 450);
        check("rst_ypos", ypos, 250);
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_step_done", step_done, 0);
        check("rst_landed", landed, 0);

        // First tick after reset release, single right step with latency checks.
        right = 1'b1;
        rst = 1'b0;
        n = 0;
        while (!busy && n < 10) begin @(negedge clk); n++; end
        check("first_tick", n, 4);
        @(negedge clk);
        check("r1_grant", grant, 4'b0001);
        @(negedge clk);
        check("r1_xpos", xpos, 452);
        check("r1_step_done", step_done, 1);
        check("r1_grant_clr", grant, 0);
        check("r1_busy", busy, 0);
        right = 1'b0;
        @(negedge clk);
        check("r1_step_done_low", step_done, 0);

        // Asynchronous reset while in APPLY with a right grant pending.
        right = 1'b1;
        n = 0;
        while (busy && n < 20) begin @(negedge clk); n++; end
        n = 0;
        while (!busy && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        check("mid_grant", grant, 4'b0001);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_xpos", xpos, 450);
        check("mid_rst_ypos", ypos, 250);
        check("mid_rst_grant", grant, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_landed", landed, 0);
        @(negedge clk);
        right = 1'b0;
        rst = 1'b0;

        // Round-robin with all four requests held.
        do_step(4'b1111, 1'b1, 4'b0001, 452, 250, 1'b0);
        do_step(4'b1111, 1'b1, 4'b0010, 450, 250, 1'b0);
        do_step(4'b1111, 1'b1, 4'b0100, 450, 252, 1'b0);
        do_step(4'b1111, 1'b1, 4'b1000, 450, 250, 1'b0);
        do_step(4'b1111, 1'b1, 4'b0001, 452, 250, 1'b0);

        // Disable for 20 cycles: nothing may move; counter held at 2.
        enable = 1'b0;
        any_busy = 1'b0; any_grant = 1'b0; any_move = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (busy) any_busy = 1'b1;
            if (grant != 4'b0000) any_grant = 1'b1;
            if (xpos != 10'd452 || ypos != 10'd250) any_move = 1'b1;
        end
        check("en_off_busy", any_busy, 0);
        check("en_off_grant", any_grant, 0);
        check("en_off_move", any_move, 0);
        enable = 1'b1;
        n = 0;
        while (!busy && n < 10) begin @(negedge clk); n++; end
        check("en_resume", n, 2);
        @(negedge clk);
        check("en_grant", grant, 4'b0010);
        @(negedge clk);
        check("en_xpos", xpos, 450);

        // Horizontal wrap: walk right to the edge, wrap, walk to 777, wrap, go left.
        for (int k = 0; k < 163; k++) do_step(4'b0001, 1'b0, 0, 0, 0, 1'b0);
        do_step(4'b0001, 1'b1, 4'b0001, 778, 250, 1'b0);
        do_step(4'b0001, 1'b1, 4'b0001, 149, 250, 1'b0);
        for (int k = 0; k < 313; k++) do_step(4'b0001, 1'b0, 0, 0, 0, 1'b0);
        do_step(4'b0001, 1'b1, 4'b0001, 777, 250, 1'b0);
        do_step(4'b0001, 1'b1, 4'b0001, 149, 250, 1'b0);
        do_step(4'b0010, 1'b1, 4'b0010, 778, 250, 1'b0);

        // Down clamp at the sand: 250 + 2k until tick 72 hits 394.
        for (int k = 1; k <= 80; k++) begin
            ey = (k >= 72) ? 10'd394 : 10'(250 + 2 * k);
            do_step(4'b0100, 1'b1, 4'b0100, 778, ey, k >= 72);
        end

        // Up clamp at the top: 394 - 2k until tick 177 hits 40.
        for (int k = 1; k <= 178; k++) begin
            ey = (k >= 177) ? 10'd40 : 10'(394 - 2 * k);
            do_step(4'b1000, 1'b1, 4'b1000, 778, ey, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
